// File: rtl/net_mul_r_if.sv
// Operand/result handshake bundle for the net_mul_r multiply-add pipeline.
interface net_mul_r_if #(
  parameter int unsigned DW = 32
) ();

  logic              start_i;
  logic [DW-1:0]     A_i;
  logic [DW-1:0]     B_i;
  logic [DW-1:0]     C_i;
  logic              ready_o;
  logic              end_o;
  logic [2*DW-1:0]   result_o;

  // Requester side: issues operands, observes completion.
  modport master (
    output start_i,
    output A_i,
    output B_i,
    output C_i,
    input  ready_o,
    input  end_o,
    input  result_o
  );

  // Multiplier side.
  modport slave (
    input  start_i,
    input  A_i,
    input  B_i,
    input  C_i,
    output ready_o,
    output end_o,
    output result_o
  );

endinterface

// File: rtl/net_mul_r.sv
// Pipelined shift-add multiply-accumulate: result = A*B + C in 2*DW bits.
// Each of the N_PIPE stages folds in DW/N_PIPE multiplier bits (LSB first);
// only one operation is in flight, so operands are held in a single register.
module net_mul_r #(
  parameter int unsigned DW     = 32,
  parameter int unsigned N_PIPE = 4
) (
  input logic        clk_i,
  input logic        rst_ni,
  net_mul_r_if.slave bus
);

  localparam int unsigned CPR = DW / N_PIPE;
  localparam int unsigned PW  = 2 * DW;

  if (((DW % N_PIPE) != 0) || (N_PIPE < 2)) begin : g_bad_cfg
    $fatal(1, "net_mul_r: DW must be a multiple of N_PIPE and N_PIPE must be >= 2");
  end

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                         state_q, state_d;
  logic   [N_PIPE-1:0]            en_r;
  logic   [DW-1:0]                op_a_q, op_b_q;
  logic   [N_PIPE-2:0][PW-1:0]    sum_q, sum_d;
  logic   [PW-1:0]                result_q;
  logic   [N_PIPE-1:0][PW-1:0]    stage_out;
  logic                           accept;

  assign accept = bus.start_i && (state_q == StIdle);

  // Per-stage partial product over this stage's multiplier bit slice.
  for (genvar k = 0; k < N_PIPE; k++) begin : g_stage
    logic [DW-1:0] src_a;
    logic [DW-1:0] src_b;
    logic [PW-1:0] stage_in;
    logic [PW-1:0] pp;
    logic [DW-1:0] bits;
    logic [PW-1:0] addend;

    if (k == 0) begin : g_first
      // First slice works straight off the bus so it lands in the accept edge.
      assign src_a    = bus.A_i;
      assign src_b    = bus.B_i;
      assign stage_in = {{DW{1'b0}}, bus.C_i};
    end else begin : g_rest
      assign src_a    = op_a_q;
      assign src_b    = op_b_q;
      assign stage_in = sum_q[k-1];
    end

    // Shift-add over CPR multiplier bits starting at bit k*CPR.
    always_comb begin
      pp     = '0;
      bits   = src_b >> (k * CPR);
      addend = {{DW{1'b0}}, src_a} << (k * CPR);
      for (int i = 0; i < CPR; i++) begin
        if (bits[0]) begin
          pp = pp + addend;
        end
        addend = addend << 1;
        bits   = bits >> 1;
      end
    end

    assign stage_out[k] = stage_in + pp;
  end

  // Stage registers: first stage loads only on accept, the rest follow the chain.
  always_comb begin
    sum_d = stage_out[N_PIPE-2:0];
    if (!accept) begin
      sum_d[0] = sum_q[0];
    end
  end

  // Control FSM: idle until accept, busy until the token leaves the last stage.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StBusy;
      StBusy: if (en_r[N_PIPE-1]) state_d = StIdle;
    endcase
  end

  // Datapath, occupancy token and state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      en_r     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      sum_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      en_r    <= {en_r[N_PIPE-2:0], accept};
      sum_q   <= sum_d;
      if (accept) begin
        op_a_q <= bus.A_i;
        op_b_q <= bus.B_i;
      end
      if (en_r[N_PIPE-2]) begin
        result_q <= stage_out[N_PIPE-1];
      end
    end
  end

  assign bus.ready_o  = ~|en_r;
  assign bus.end_o    = en_r[N_PIPE-1];
  assign bus.result_o = result_q;

endmodule
